// File: rtl/sqd_param_pkg.sv
// Shared constants and helpers for the serial sequence detector family.
// Default flag pattern plus the width needed for the fill counter.
package sqd_param_pkg;

  localparam int SQD_FLAG_W = 7;
  localparam logic [SQD_FLAG_W-1:0] SQD_FLAG_PAT = 7'b0111110;

  // Fill must be able to hold the value pat_w itself, not just pat_w-1.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sqd_param_if.sv
// Bit-stream input and detection-result bundle for sqd_param.
// The master drives the stream; the slave (detector) returns the flags.
interface sqd_param_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             inp;
  logic             clr_cnt;
  logic             w;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (output en, inp, clr_cnt, input w, match_cnt, cnt_sat);
  modport slave  (input en, inp, clr_cnt, output w, match_cnt, cnt_sat);
endinterface

// File: rtl/sqd_param_sat_counter.sv
// Saturating up-counter with a sticky saturation flag and synchronous clear.
// Clear wins over a simultaneous increment.
module sqd_param_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sat_reg, sat_next;

  always_comb begin
    cnt_next = cnt_reg;
    sat_next = sat_reg;
    if (clr) begin
      cnt_next = '0;
      sat_next = 1'b0;
    end else if (inc) begin
      if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
      // Flag goes up as soon as the count lands on all-ones, and stays up.
      if (cnt_next == CNT_MAX) sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      sat_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      sat_reg <= sat_next;
    end
  end

  assign cnt = cnt_reg;
  assign sat = sat_reg;

endmodule

// File: rtl/sqd_param.sv
// Parametrised serial pattern detector: shifts in one bit per enabled clock and
// raises w for one cycle each time the last PAT_W received bits equal PATTERN.
module sqd_param
  import sqd_param_pkg::*;
#(
  parameter int               PAT_W   = SQD_FLAG_W,
  parameter logic [PAT_W-1:0] PATTERN = SQD_FLAG_PAT,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input logic         clk,
  input logic         rst,
  sqd_param_if.slave  bus
);
  localparam int             FW        = fill_width(PAT_W);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

  if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_param_check
    $error("sqd_param: PAT_W must be 2..32 and CNT_W >= 1");
  end

  logic [PAT_W-1:0] hist_reg, hist_next;
  logic [FW-1:0]    fill_reg, fill_next;
  logic [PAT_W-1:0] bit_eq;
  logic             w_reg;
  logic             m;

  always_comb begin
    hist_next = hist_reg;
    fill_next = fill_reg;
    if (bus.en) begin
      hist_next = {hist_reg[PAT_W-2:0], bus.inp};
      if (fill_reg != FILL_FULL) fill_next = fill_reg + 1'b1;
    end
  end

  // Compare against the value being loaded so w lands one cycle after the last bit.
  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
    assign bit_eq[gi] = hist_next[gi] ~^ PATTERN[gi];
  end

  assign m = bus.en && (fill_next == FILL_FULL) && (&bit_eq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= '0;
      fill_reg <= '0;
      w_reg    <= 1'b0;
    end else begin
      hist_reg <= hist_next;
      // Non-overlapping mode forgets the matched bits by restarting the fill.
      fill_reg <= (m && !OVERLAP) ? '0 : fill_next;
      w_reg    <= m;
    end
  end

  assign bus.w = w_reg;

  sqd_param_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (m),
    .clr (bus.clr_cnt),
    .cnt (bus.match_cnt),
    .sat (bus.cnt_sat)
  );

endmodule

// File: tb/tb_sqd_param.sv
// Bench for sqd_param: four configurations share one clock and reset.
// u0 default/overlap, u1 non-overlap, u2 CNT_W=2, u3 PAT_W=4 pattern 1011.
module tb_sqd_param;

  logic       clk;
  logic       rst;
  logic [3:0] en_v, inp_v, clr_v;
  logic [3:0] w_v, sat_v;
  logic [7:0] cnt_v [4];

  int total;
  int passed;

  sqd_param_if #(.CNT_W(8)) bus0 ();
  sqd_param_if #(.CNT_W(8)) bus1 ();
  sqd_param_if #(.CNT_W(2)) bus2 ();
  sqd_param_if #(.CNT_W(8)) bus3 ();

  sqd_param #(.OVERLAP(1'b1)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  sqd_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  sqd_param #(.CNT_W(2))      u2 (.clk(clk), .rst(rst), .bus(bus2));
  sqd_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u3 (.clk(clk), .rst(rst), .bus(bus3));

  assign bus0.en = en_v[0]; assign bus0.inp = inp_v[0]; assign bus0.clr_cnt = clr_v[0];
  assign bus1.en = en_v[1]; assign bus1.inp = inp_v[1]; assign bus1.clr_cnt = clr_v[1];
  assign bus2.en = en_v[2]; assign bus2.inp = inp_v[2]; assign bus2.clr_cnt = clr_v[2];
  assign bus3.en = en_v[3]; assign bus3.inp = inp_v[3]; assign bus3.clr_cnt = clr_v[3];

  assign w_v   = {bus3.w, bus2.w, bus1.w, bus0.w};
  assign sat_v = {bus3.cnt_sat, bus2.cnt_sat, bus1.cnt_sat, bus0.cnt_sat};
  assign cnt_v[0] = bus0.match_cnt;
  assign cnt_v[1] = bus1.match_cnt;
  assign cnt_v[2] = {6'd0, bus2.match_cnt};
  assign cnt_v[3] = bus3.match_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remembered received bits per instance, compared tail-to-pattern.
  int          pw   [4] = '{7, 7, 7, 4};
  logic [31:0] pat  [4] = '{32'b0111110, 32'b0111110, 32'b0111110, 32'b1011};
  bit          ovl  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          cmax [4] = '{255, 255, 3, 255};
  bit          stream [4][$];
  int          mcnt [4];
  bit          msat [4];
  bit          mw   [4];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      stream[k].delete();
      mcnt[k] = 0;
      msat[k] = 1'b0;
      mw[k]   = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit e, input bit b, input bit c);
    bit hit;
    int n;
    hit = 1'b0;
    if (e) begin
      stream[k].push_back(b);
      n = stream[k].size();
      if (n >= pw[k]) begin
        hit = 1'b1;
        for (int i = 0; i < pw[k]; i++)
          if (stream[k][n - pw[k] + i] != pat[k][pw[k] - 1 - i]) hit = 1'b0;
      end
      if (hit && !ovl[k]) stream[k].delete();
      else if (stream[k].size() > 40) void'(stream[k].pop_front());
    end
    mw[k] = hit;
    if (c) begin
      mcnt[k] = 0;
      msat[k] = 1'b0;
    end else if (hit) begin
      if (mcnt[k] < cmax[k]) mcnt[k]++;
      if (mcnt[k] == cmax[k]) msat[k] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_v  = '0;
    clr_v = '0;
    inp_v = '0;
    rst   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic feed(input int k, input logic [31:0] bits, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      en_v[k]  = 1'b1;
      inp_v[k] = bits[n - 1 - i];
      tick();
      if (w_v[k]) pulses++;
    end
    en_v[k] = 1'b0;
  endtask

  typedef struct {
    logic en, inp, clr;
    logic w;
    int   cnt;
    logic sat;
  } vec_t;

  function automatic vec_t mk(logic en, logic inp, logic clr, logic w, int cnt, logic sat);
    vec_t v;
    v.en = en; v.inp = inp; v.clr = clr; v.w = w; v.cnt = cnt; v.sat = sat;
    return v;
  endfunction

  vec_t tab [15];

  initial begin
    int p;
    int u1_pulses;
    logic [6:0] flag;
    total  = 0;
    passed = 0;
    flag   = 7'b0111110;

    // Stream 0111110 111110 on u0 (overlap), then a held cycle and a clear.
    tab[0] = mk(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) tab[i] = mk(1, 1, 0, 0, 0, 0);
    tab[6] = mk(1, 0, 0, 1, 1, 0);
    for (int i = 7; i <= 11; i++) tab[i] = mk(1, 1, 0, 0, 1, 0);
    tab[12] = mk(1, 0, 0, 1, 2, 0);
    tab[13] = mk(0, 1, 0, 0, 2, 0);
    tab[14] = mk(0, 0, 1, 0, 0, 0);

    en_v = '0; inp_v = '0; clr_v = '0; rst = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("async_rst_w%0d", k), int'(w_v[k]), 0);
      chk($sformatf("async_rst_cnt%0d", k), int'(cnt_v[k]), 0);
      chk($sformatf("async_rst_sat%0d", k), int'(sat_v[k]), 0);
    end
    do_reset();

    // Table run; u1 sees the same bits to show the non-overlap difference.
    u1_pulses = 0;
    for (int i = 0; i < 15; i++) begin
      en_v[0] = tab[i].en; inp_v[0] = tab[i].inp; clr_v[0] = tab[i].clr;
      en_v[1] = (i < 13) ? tab[i].en : 1'b0; inp_v[1] = tab[i].inp;
      tick();
      if (w_v[1]) u1_pulses++;
      chk($sformatf("tab%0d_w", i),   int'(w_v[0]),   int'(tab[i].w));
      chk($sformatf("tab%0d_cnt", i), int'(cnt_v[0]), tab[i].cnt);
      chk($sformatf("tab%0d_sat", i), int'(sat_v[0]), int'(tab[i].sat));
    end
    chk("nonovl_pulses", u1_pulses, 1);
    chk("nonovl_cnt", int'(cnt_v[1]), 1);

    // en low between every bit: single pulse on the enabled edge taking the last 0.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      en_v[0] = 1'b1; inp_v[0] = flag[6 - i];
      tick();
      chk($sformatf("entog_on%0d", i), int'(w_v[0]), (i == 6) ? 1 : 0);
      en_v[0] = 1'b0; inp_v[0] = 1'($urandom);
      tick();
      chk($sformatf("entog_off%0d", i), int'(w_v[0]), 0);
    end
    chk("entog_cnt", int'(cnt_v[0]), 1);

    // Power-up zeros must not stand in for the leading 0.
    do_reset();
    feed(0, 32'b111110, 6, p);
    chk("no_lead0_pulses", p, 0);
    chk("no_lead0_cnt", int'(cnt_v[0]), 0);

    // Reset in mid-pattern throws away the partial history.
    do_reset();
    feed(0, 32'b0111, 4, p);
    do_reset();
    feed(0, 32'b110, 3, p);
    chk("midrst_pulses", p, 0);

    // Two-bit counter saturates at 3 and raises the sticky flag.
    do_reset();
    feed(2, 32'b0111110, 7, p);
    chk("sat_det1_w", int'(w_v[2]), 1);
    chk("sat_det1_cnt", int'(cnt_v[2]), 1);
    chk("sat_det1_sat", int'(sat_v[2]), 0);
    for (int n = 2; n <= 5; n++) begin
      feed(2, 32'b111110, 6, p);
      chk($sformatf("sat_det%0d_pulses", n), p, 1);
      chk($sformatf("sat_det%0d_cnt", n), int'(cnt_v[2]), (n < 3) ? n : 3);
      chk($sformatf("sat_det%0d_sat", n), int'(sat_v[2]), (n >= 3) ? 1 : 0);
    end
    feed(2, 32'b11111, 5, p);
    en_v[2] = 1'b1; inp_v[2] = 1'b0; clr_v[2] = 1'b1;
    tick();
    chk("clr_vs_det_w", int'(w_v[2]), 1);
    chk("clr_vs_det_cnt", int'(cnt_v[2]), 0);
    chk("clr_vs_det_sat", int'(sat_v[2]), 0);
    en_v[2] = 1'b0; clr_v[2] = 1'b0;
    tick();
    chk("after_clr_cnt", int'(cnt_v[2]), 0);

    // Random stream on every instance against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        en_v[k]  = ($urandom_range(4, 0) != 0);
        inp_v[k] = 1'($urandom);
        clr_v[k] = ($urandom_range(99, 0) == 0);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        model_step(k, en_v[k], inp_v[k], clr_v[k]);
        chk($sformatf("rnd%0d_u%0d_w", cyc, k),   int'(w_v[k]),   int'(mw[k]));
        chk($sformatf("rnd%0d_u%0d_cnt", cyc, k), int'(cnt_v[k]), mcnt[k]);
        chk($sformatf("rnd%0d_u%0d_sat", cyc, k), int'(sat_v[k]), int'(msat[k]));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
